// File: rtl/db_pulse_gen.sv
// Push-button debouncer: two-flop synchronizer, four-state qualifier FSM,
// registered debounced level plus one-cycle press/release pulses.
module db_pulse_gen #(
    parameter int DB_COUNT = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic db_level,
    output logic press_p,
    output logic release_p
);

    localparam int CW = $clog2(DB_COUNT);
    // The LO/HI sample that leaves the stable state is the first stable cycle,
    // so the wait state qualifies on the DB_COUNT-th consecutive sample.
    localparam logic [CW-1:0] LAST = CW'(DB_COUNT - 2);

    typedef enum logic [1:0] {
        LO,
        WAIT_HI,
        HI,
        WAIT_LO
    } state_t;

    logic          r_sync1;
    logic          r_in_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_db_level;
    logic          r_press;
    logic          r_release;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_db_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_in_s     <= 1'b0;
            r_state    <= LO;
            r_cnt      <= '0;
            r_db_level <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_sync1    <= in;
            r_in_s     <= r_sync1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_db_level <= w_db_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_db_nxt      = r_db_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        unique case (r_state)
            LO: begin
                if (r_in_s) w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (!r_in_s) begin
                    w_state_nxt = LO;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = HI;
                    w_db_nxt    = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HI: begin
                if (!r_in_s) w_state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (r_in_s) begin
                    w_state_nxt = HI;
                end else if (r_cnt == LAST) begin
                    w_state_nxt   = LO;
                    w_db_nxt      = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = LO;
            end
        endcase
    end

    assign db_level  = r_db_level;
    assign press_p   = r_press;
    assign release_p = r_release;

endmodule

// File: tb/tb_db_pulse_gen.sv
// Bench for db_pulse_gen (DB_COUNT=4): directed vector table, async reset
// check, then random bouncing input against a run-length reference model.
module tb_db_pulse_gen;

    localparam int DBC = 4;

    logic clk = 1'b0;
    logic reset;
    logic in;
    logic db_level;
    logic press_p;
    logic release_p;

    always #5 clk = ~clk;

    db_pulse_gen #(.DB_COUNT(DBC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .db_level  (db_level),
        .press_p   (press_p),
        .release_p (release_p)
    );

    typedef struct {
        logic rst_n;
        logic in;
        logic db;
        logic pr;
        logic rl;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: in_s is in delayed two edges; qualify once in_s has
    // differed from the debounced level for DBC consecutive samples.
    logic m_dly[2];
    logic m_db, m_pr, m_rl;
    int   m_run;

    task automatic model_edge();
        if (!reset) begin
            m_dly = '{1'b0, 1'b0};
            m_db  = 1'b0;
            m_pr  = 1'b0;
            m_rl  = 1'b0;
            m_run = 0;
        end else begin
            m_pr = 1'b0;
            m_rl = 1'b0;
            if (m_dly[1] != m_db) m_run++;
            else m_run = 0;
            if (m_run == DBC) begin
                m_db  = m_dly[1];
                m_pr  = m_dly[1];
                m_rl  = !m_dly[1];
                m_run = 0;
            end
            m_dly[1] = m_dly[0];
            m_dly[0] = in;
        end
    endtask

    task automatic check(string nm, logic db, logic pr, logic rl);
        n_vec++;
        if (db_level !== db || press_p !== pr || release_p !== rl) begin
            n_err++;
            $display("FAIL %s @%0t: got db=%b p=%b r=%b, want db=%b p=%b r=%b",
                     nm, $time, db_level, press_p, release_p, db, pr, rl);
        end
    endtask

    task automatic step(logic r, logic i);
        @(negedge clk);
        reset = r;
        in    = i;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic void add(logic r, logic i, logic db, logic pr,
                                logic rl, int n);
        vec_t v;
        v.rst_n = r;
        v.in    = i;
        v.db    = db;
        v.pr    = pr;
        v.rl    = rl;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    initial begin
        reset = 1'b0;
        in    = 1'b0;
        m_dly = '{1'b0, 1'b0};
        m_db  = 1'b0;
        m_pr  = 1'b0;
        m_rl  = 1'b0;
        m_run = 0;

        // reset
        add(0, 0, 0, 0, 0, 2);
        // clean press: pulse after edge 6
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 3);
        // release
        add(1, 0, 1, 0, 0, 5);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 3);
        // bounce 3 high / 3 low / 2 high
        add(1, 1, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 6);
        // exactly DB_COUNT-long pulse qualifies both edges
        add(1, 1, 0, 0, 0, 4);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 1);
        add(1, 0, 1, 0, 0, 3);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 2);
        // mid-count reset
        add(1, 1, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 2);
        // startup with in already high
        add(0, 1, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 2);

        foreach (tbl[k]) begin
            step(tbl[k].rst_n, tbl[k].in);
            check($sformatf("tbl[%0d]", k), tbl[k].db, tbl[k].pr, tbl[k].rl);
        end

        // reset must clear outputs without a clock edge
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_rst", 1'b0, 1'b0, 1'b0);
        step(0, 0);
        check("rst_hold", 1'b0, 1'b0, 1'b0);

        for (int s = 0; s < 300; s++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * DBC + 2);
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < $urandom_range(1, 2); k++) begin
                    step(0, lvl);
                    check("rand_rst", m_db, m_pr, m_rl);
                end
            end
            for (int k = 0; k < len; k++) begin
                step(1, lvl);
                check($sformatf("rand[%0d]", s), m_db, m_pr, m_rl);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
